// File: rtl/exec_stage_if.sv
// Issue/result bundle for exec_stage: issue request with operands and
// forwarding sources, flush, and the registered result handshake.
interface exec_stage_if #(
    parameter int XLEN = 32,
    parameter int NFWD = 2
);
    logic                   IN_VALID;
    logic                   IN_READY;
    logic [3:0]             OP;
    logic [4:0]             RS1_IDX;
    logic [4:0]             RS2_IDX;
    logic [4:0]             RD_IDX;
    logic [XLEN-1:0]        RS1_REG;
    logic [XLEN-1:0]        RS2_REG;
    logic [XLEN-1:0]        IMM;
    logic [XLEN-1:0]        PC;
    logic [NFWD-1:0]        FWD_VALID;
    logic [5*NFWD-1:0]      FWD_IDX;
    logic [XLEN*NFWD-1:0]   FWD_VAL;
    logic                   FLUSH;
    logic                   OUT_VALID;
    logic                   OUT_READY;
    logic [4:0]             OUT_RD_IDX;
    logic [XLEN-1:0]        OUT_RESULT;
    logic                   BR_TAKEN;
    logic [XLEN-1:0]        BR_DEST;

    // Issuer side: drives requests, consumes results.
    modport master (
        output IN_VALID, OP, RS1_IDX, RS2_IDX, RD_IDX, RS1_REG, RS2_REG,
               IMM, PC, FWD_VALID, FWD_IDX, FWD_VAL, FLUSH, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_RD_IDX, OUT_RESULT, BR_TAKEN, BR_DEST
    );

    // Execute stage side.
    modport slave (
        input  IN_VALID, OP, RS1_IDX, RS2_IDX, RD_IDX, RS1_REG, RS2_REG,
               IMM, PC, FWD_VALID, FWD_IDX, FWD_VAL, FLUSH, OUT_READY,
        output IN_READY, OUT_VALID, OUT_RD_IDX, OUT_RESULT, BR_TAKEN, BR_DEST
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU/branch ops, iterative shift-add multiply
// and restoring divide (one bit per cycle), operand forwarding, and a
// registered valid/ready result port with flush support.
module exec_stage #(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic         CLK,
    input  logic         RST,
    exec_stage_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_DIV  = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_REM  = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;
    localparam logic [3:0] OP_BEQ  = 4'd12;
    localparam logic [3:0] OP_BNE  = 4'd13;
    localparam logic [3:0] OP_JAL  = 4'd14;
    localparam logic [3:0] OP_JALR = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Two's complement negate within the datapath width.
    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return (~x) + ONE;
    endfunction

    // Operand source select: x0 is hardwired zero, then the lowest-numbered
    // matching forwarding source, then the register file value.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]           idx,
        input logic [XLEN-1:0]      reg_val,
        input logic [NFWD-1:0]      fv,
        input logic [5*NFWD-1:0]    fi,
        input logic [XLEN*NFWD-1:0] fval
    );
        logic [XLEN-1:0] r;
        r = reg_val;
        for (int k = NFWD - 1; k >= 0; k--) begin
            r = (fv[k] && (fi[5*k +: 5] == idx)) ? fval[XLEN*k +: XLEN] : r;
        end
        return (idx == 5'd0) ? '0 : r;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               is_multi_s;
    logic               last_iter_s;
    logic [XLEN-1:0]    rs1_val_s;
    logic [XLEN-1:0]    rs2_val_s;

    logic [XLEN-1:0]    alu_res_s;
    logic [XLEN-1:0]    alu_dest_s;
    logic               alu_taken_s;
    logic [4:0]         alu_rd_s;

    logic               signed_div_s;
    logic               neg_a_s;
    logic               neg_b_s;
    logic [XLEN-1:0]    mag_a_s;
    logic [XLEN-1:0]    mag_b_s;

    // Iteration state. work_a holds the multiplicand (MUL) or divisor
    // magnitude (divides); work_b holds the multiplier or the dividend that
    // is shifted out while quotient bits shift in; acc_r is the running
    // product or partial remainder.
    logic [3:0]         op_r;
    logic [4:0]         rd_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [XLEN-1:0]    work_a_r;
    logic [XLEN-1:0]    work_b_r;
    logic [XLEN-1:0]    acc_r;
    logic [XLEN-1:0]    dvd_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               div_zero_r;

    logic [XLEN-1:0]    mul_acc_s;
    logic [XLEN:0]      rem_sh_s;
    logic [XLEN:0]      diff_s;
    logic               sub_ok_s;
    logic [XLEN-1:0]    rem_nxt_s;
    logic [XLEN-1:0]    q_nxt_s;
    logic [XLEN-1:0]    mc_res_s;

    logic               out_valid_r;
    logic [4:0]         out_rd_r;
    logic [XLEN-1:0]    out_result_r;
    logic               br_taken_r;
    logic [XLEN-1:0]    br_dest_r;

    assign in_ready_s  = ((state_r == IDLE) || ((state_r == HOLD) && bus.OUT_READY))
                         && !bus.FLUSH && !RST;
    assign accept_s    = bus.IN_VALID && in_ready_s;
    assign is_multi_s  = (bus.OP >= OP_MUL) && (bus.OP <= OP_REMU);
    assign last_iter_s = (cnt_r == LAST_ITER);

    assign rs1_val_s = resolve(bus.RS1_IDX, bus.RS1_REG, bus.FWD_VALID, bus.FWD_IDX, bus.FWD_VAL);
    assign rs2_val_s = resolve(bus.RS2_IDX, bus.RS2_REG, bus.FWD_VALID, bus.FWD_IDX, bus.FWD_VAL);

    // Signed divides run on magnitudes; signs are reapplied at the end.
    assign signed_div_s = (bus.OP == OP_DIV) || (bus.OP == OP_REM);
    assign neg_a_s      = signed_div_s && rs1_val_s[XLEN-1];
    assign neg_b_s      = signed_div_s && rs2_val_s[XLEN-1];
    assign mag_a_s      = neg_a_s ? negate(rs1_val_s) : rs1_val_s;
    assign mag_b_s      = neg_b_s ? negate(rs2_val_s) : rs2_val_s;

    assign bus.IN_READY   = in_ready_s;
    assign bus.OUT_VALID  = out_valid_r;
    assign bus.OUT_RD_IDX = out_rd_r;
    assign bus.OUT_RESULT = out_result_r;
    assign bus.BR_TAKEN   = br_taken_r;
    assign bus.BR_DEST    = br_dest_r;

    // Single-cycle ALU, branch and jump results from the resolved operands.
    always_comb begin
        alu_res_s   = '0;
        alu_dest_s  = '0;
        alu_taken_s = 1'b0;
        alu_rd_s    = bus.RD_IDX;
        case (bus.OP)
            OP_ADD:  alu_res_s = rs1_val_s + rs2_val_s;
            OP_SUB:  alu_res_s = rs1_val_s - rs2_val_s;
            OP_AND:  alu_res_s = rs1_val_s & rs2_val_s;
            OP_OR:   alu_res_s = rs1_val_s | rs2_val_s;
            OP_XOR:  alu_res_s = rs1_val_s ^ rs2_val_s;
            OP_SLT:  alu_res_s = ($signed(rs1_val_s) < $signed(rs2_val_s)) ? ONE : '0;
            OP_SLTU: alu_res_s = (rs1_val_s < rs2_val_s) ? ONE : '0;
            OP_BEQ: begin
                alu_taken_s = (rs1_val_s == rs2_val_s);
                alu_dest_s  = bus.PC + bus.IMM;
                alu_rd_s    = 5'd0;
            end
            OP_BNE: begin
                alu_taken_s = (rs1_val_s != rs2_val_s);
                alu_dest_s  = bus.PC + bus.IMM;
                alu_rd_s    = 5'd0;
            end
            OP_JAL: begin
                alu_taken_s = 1'b1;
                alu_dest_s  = bus.PC + bus.IMM;
                alu_res_s   = bus.PC + PC_STEP;
            end
            OP_JALR: begin
                alu_taken_s = 1'b1;
                alu_dest_s  = (rs1_val_s + bus.IMM) & ~ONE;
                alu_res_s   = bus.PC + PC_STEP;
            end
            default: alu_res_s = '0;
        endcase
    end

    // One multiply/divide iteration and the sign-fixed final result.
    always_comb begin
        mul_acc_s = work_b_r[0] ? (acc_r + work_a_r) : acc_r;
        rem_sh_s  = {acc_r, work_b_r[XLEN-1]};
        diff_s    = rem_sh_s - {1'b0, work_a_r};
        sub_ok_s  = !diff_s[XLEN];
        rem_nxt_s = sub_ok_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
        q_nxt_s   = {work_b_r[XLEN-2:0], sub_ok_s};
        case (op_r)
            OP_MUL:  mc_res_s = mul_acc_s;
            OP_DIV,
            OP_DIVU: mc_res_s = div_zero_r ? '1 : (neg_q_r ? negate(q_nxt_s) : q_nxt_s);
            OP_REM,
            OP_REMU: mc_res_s = div_zero_r ? dvd_r : (neg_r_r ? negate(rem_nxt_s) : rem_nxt_s);
            default: mc_res_s = '0;
        endcase
    end

    // Next-state logic; flush aborts whatever is in flight.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.FLUSH) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = is_multi_s ? BUSY : HOLD;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                BUSY: begin
                    if (last_iter_s) begin
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end
                HOLD: begin
                    if (accept_s) begin
                        state_nxt_s = is_multi_s ? BUSY : HOLD;
                    end else if (bus.OUT_READY) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch, iteration datapath and registered result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_r         <= 4'd0;
            rd_r         <= 5'd0;
            cnt_r        <= '0;
            work_a_r     <= '0;
            work_b_r     <= '0;
            acc_r        <= '0;
            dvd_r        <= '0;
            neg_q_r      <= 1'b0;
            neg_r_r      <= 1'b0;
            div_zero_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_rd_r     <= 5'd0;
            out_result_r <= '0;
            br_taken_r   <= 1'b0;
            br_dest_r    <= '0;
        end else if (bus.FLUSH) begin
            out_valid_r <= 1'b0;
            cnt_r       <= '0;
        end else if (accept_s && !is_multi_s) begin
            out_valid_r  <= 1'b1;
            out_rd_r     <= alu_rd_s;
            out_result_r <= alu_res_s;
            br_taken_r   <= alu_taken_s;
            br_dest_r    <= alu_dest_s;
        end else if (accept_s) begin
            out_valid_r <= 1'b0;
            op_r        <= bus.OP;
            rd_r        <= bus.RD_IDX;
            cnt_r       <= '0;
            acc_r       <= '0;
            dvd_r       <= rs1_val_s;
            neg_q_r     <= neg_a_s ^ neg_b_s;
            neg_r_r     <= neg_a_s;
            div_zero_r  <= (rs2_val_s == '0);
            if (bus.OP == OP_MUL) begin
                work_a_r <= rs1_val_s;
                work_b_r <= rs2_val_s;
            end else begin
                work_a_r <= mag_b_s;
                work_b_r <= mag_a_s;
            end
        end else if (state_r == BUSY) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
            if (op_r == OP_MUL) begin
                acc_r    <= mul_acc_s;
                work_a_r <= {work_a_r[XLEN-2:0], 1'b0};
                work_b_r <= {1'b0, work_b_r[XLEN-1:1]};
            end else begin
                acc_r    <= rem_nxt_s;
                work_b_r <= q_nxt_s;
            end
            if (last_iter_s) begin
                out_valid_r  <= 1'b1;
                out_rd_r     <= rd_r;
                out_result_r <= mc_res_s;
                br_taken_r   <= 1'b0;
                br_dest_r    <= '0;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if ((state_r == HOLD) && bus.OUT_READY) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end
endmodule
